// File: rtl/gpio_irq_ctrl.sv
// GPIO bank: synchronised and debounced pad inputs, atomic output updates and
// per-pin edge/level interrupt status behind a req/ack register interface.
module gpio_irq_ctrl #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [11:0]           addr,
  input  logic [63:0]           wdata,
  output logic                  ack,
  output logic [63:0]           rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_dir,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  localparam logic [8:0] IDX_OUT  = 9'd0;
  localparam logic [8:0] IDX_SET  = 9'd1;
  localparam logic [8:0] IDX_CLR  = 9'd2;
  localparam logic [8:0] IDX_TGL  = 9'd3;
  localparam logic [8:0] IDX_DIR  = 9'd4;
  localparam logic [8:0] IDX_IN   = 9'd5;
  localparam logic [8:0] IDX_EN   = 9'd6;
  localparam logic [8:0] IDX_TYPE = 9'd7;
  localparam logic [8:0] IDX_POL  = 9'd8;
  localparam logic [8:0] IDX_BOTH = 9'd9;
  localparam logic [8:0] IDX_STAT = 9'd10;
  localparam logic [8:0] IDX_DEB  = 9'd11;

  logic                  ack_q;
  logic [63:0]           rdata_q;
  logic [63:0]           rd_val;
  logic [W-1:0]          out_q, out_d;
  logic [W-1:0]          dir_q, dir_d;
  logic [W-1:0]          en_q, en_d;
  logic [W-1:0]          type_q, type_d;
  logic [W-1:0]          pol_q, pol_d;
  logic [W-1:0]          both_q, both_d;
  logic [W-1:0]          stat_q, stat_d;
  logic [DEBOUNCE_W-1:0] deb_q, deb_d;
  logic [W-1:0]          gout_q, gdir_q;
  logic                  irq_q;

  logic [W-1:0]          sync_q [SYNC_STAGES];
  logic [W-1:0]          sync_w;
  logic [DEBOUNCE_W-1:0] cnt_q [W];
  logic [DEBOUNCE_W-1:0] cnt_d [W];
  logic [W-1:0]          filt_q, filt_d;
  logic [W-1:0]          filt_dly_q;
  logic [DEBOUNCE_W-1:0] thr;

  logic                  accept, wr_en, rd_en;
  logic [8:0]            idx;
  logic [W-1:0]          wd;
  logic [W-1:0]          w1c;
  logic [W-1:0]          rise, fall, edge_hit, lvl_stat, edge_stat;
  logic                  unused_w;

  assign accept   = req & ~ack_q;
  assign wr_en    = accept & we;
  assign rd_en    = accept & ~we;
  assign idx      = addr[11:3];
  assign wd       = wdata[W-1:0];
  assign unused_w = ^{addr[2:0], wdata};

  // Register writes; SET/CLR/TGL modify the current OUT so untouched bits hold.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    both_d = both_q;
    deb_d  = deb_q;
    w1c    = '0;
    if (wr_en) begin
      case (idx)
        IDX_OUT:  out_d  = wd;
        IDX_SET:  out_d  = out_q | wd;
        IDX_CLR:  out_d  = out_q & ~wd;
        IDX_TGL:  out_d  = out_q ^ wd;
        IDX_DIR:  dir_d  = wd;
        IDX_EN:   en_d   = wd;
        IDX_TYPE: type_d = wd;
        IDX_POL:  pol_d  = wd;
        IDX_BOTH: both_d = wd;
        IDX_STAT: w1c    = wd;
        IDX_DEB:  deb_d  = wdata[DEBOUNCE_W-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_OUT:  rd_val[W-1:0] = out_q;
      IDX_DIR:  rd_val[W-1:0] = dir_q;
      IDX_IN:   rd_val[W-1:0] = filt_q;
      IDX_EN:   rd_val[W-1:0] = en_q;
      IDX_TYPE: rd_val[W-1:0] = type_q;
      IDX_POL:  rd_val[W-1:0] = pol_q;
      IDX_BOTH: rd_val[W-1:0] = both_q;
      IDX_STAT: rd_val[W-1:0] = stat_q;
      IDX_DEB:  rd_val[DEBOUNCE_W-1:0] = deb_q;
      default:  ;
    endcase
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // A threshold of 0 behaves as 1: a single disagreeing cycle flips filt.
  assign thr = (deb_q == '0) ? '0 : deb_q - DEBOUNCE_W'(1);

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != filt_q[i]) begin
        if (cnt_q[i] == thr) filt_d[i] = ~filt_q[i];
        else                 cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
      end
    end
  end

  assign rise      = filt_q & ~filt_dly_q;
  assign fall      = ~filt_q & filt_dly_q;
  assign edge_hit  = en_q & ((both_q & (rise | fall)) |
                             (~both_q & ~pol_q & rise) |
                             (~both_q & pol_q & fall));
  assign lvl_stat  = en_q & (filt_q ^ pol_q);
  // New edge beats a same-cycle clear.
  assign edge_stat = edge_hit | (stat_q & ~w1c);
  assign stat_d    = (type_q & lvl_stat) | (~type_q & edge_stat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
    end else begin
      for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
      stat_q <= '0;
      deb_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      both_q <= both_d;
      stat_q <= stat_d;
      deb_q  <= deb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      gout_q  <= '0;
      gdir_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q  <= accept;
      if (rd_en) rdata_q <= rd_val;
      gout_q <= out_q;
      gdir_q <= dir_q;
      irq_q  <= |(stat_q & en_q);
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign gpio_out = gout_q;
  assign gpio_dir = gdir_q;
  assign irq      = irq_q;

endmodule
